// File: rtl/stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg -- shared definitions for the stack3 data/return stack.
//   delta_e       : stack move encoding (hold / push / pop / pop-2)
//   DEFAULT_FILL  : 16-bit pattern loaded into unused tail slots
//   clog2()       : constant-function ceil(log2(n)) for derived widths
// -----------------------------------------------------------------------------
package stack_pkg;

  typedef enum logic [1:0] {
    D_HOLD = 2'b00,
    D_PUSH = 2'b01,
    D_POP2 = 2'b10,
    D_POP  = 2'b11
  } delta_e;

  localparam logic [15:0] DEFAULT_FILL = 16'h55aa;

  // Returns the number of bits needed to index n distinct values.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/stack3_if.sv
// -----------------------------------------------------------------------------
// stack3_if -- port bundle between a stack client and the stack3 block.
//   we, delta, wd, clr_err, peek_idx       : client -> stack
//   rd, nos, peek_data, depth, empty, full,
//   overflow, underflow                    : stack -> client
// Modports: master (client side), slave (stack side).
// -----------------------------------------------------------------------------
interface stack3_if
  import stack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
);
  localparam int CW = clog2(DEPTH + 1);
  localparam int IW = clog2(DEPTH);

  logic             we;
  logic [1:0]       delta;
  logic [WIDTH-1:0] wd;
  logic             clr_err;
  logic [IW-1:0]    peek_idx;

  logic [WIDTH-1:0] rd;
  logic [WIDTH-1:0] nos;
  logic [WIDTH-1:0] peek_data;
  logic [CW-1:0]    depth;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output we, delta, wd, clr_err, peek_idx,
    input  rd, nos, peek_data, depth, empty, full, overflow, underflow
  );

  modport slave (
    input  we, delta, wd, clr_err, peek_idx,
    output rd, nos, peek_data, depth, empty, full, overflow, underflow
  );

endinterface

// File: rtl/stack_depth_ctr.sv
// -----------------------------------------------------------------------------
// stack_depth_ctr -- occupancy counter and sticky error flags for a stack.
//   clk, rst       : clock, asynchronous active-high reset
//   delta_i        : stack move (hold / push / pop / pop-2)
//   clr_err_i      : synchronous clear of both sticky flags (set wins)
//   depth_o        : valid entries, 0..DEPTH, saturating both ways
//   empty_o/full_o : depth == 0 / depth == DEPTH
//   overflow_o     : sticky, push while full
//   underflow_o    : sticky, pop/pop-2 removed more than were valid
// -----------------------------------------------------------------------------
module stack_depth_ctr
  import stack_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int CW    = clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  delta_e        delta_i,
  input  logic          clr_err_i,
  output logic [CW-1:0] depth_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          overflow_o,
  output logic          underflow_o
);

  // One extra bit so that a decrement below zero shows up as the MSB
  // (borrow) and an increment past DEPTH can be compared directly.
  localparam logic [CW:0] DEPTH_X = (CW + 1)'(DEPTH);
  localparam logic [CW:0] ONE_X   = (CW + 1)'(1);
  localparam logic [CW:0] TWO_X   = (CW + 1)'(2);

  logic [CW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic [CW:0]   cur_x, nxt_x;
  logic          ovf_evt, udf_evt;

  // NOTE: every variable assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cur_x   = {1'b0, depth_q};
    nxt_x   = cur_x;
    ovf_evt = 1'b0;
    udf_evt = 1'b0;
    case (delta_i)
      D_HOLD: ;
      D_PUSH: begin
        nxt_x = cur_x + ONE_X;
        if (nxt_x > DEPTH_X) begin
          nxt_x   = DEPTH_X;
          ovf_evt = 1'b1;
        end
      end
      D_POP: begin
        nxt_x = cur_x - ONE_X;
        if (nxt_x[CW]) begin
          nxt_x   = '0;
          udf_evt = 1'b1;
        end
      end
      D_POP2: begin
        nxt_x = cur_x - TWO_X;
        if (nxt_x[CW]) begin
          nxt_x   = '0;
          udf_evt = 1'b1;
        end
      end
    endcase
    depth_d = nxt_x[CW-1:0];
    // An error event in the same cycle as clr_err keeps the flag set.
    ovf_d   = ovf_evt | (ovf_q & ~clr_err_i);
    udf_d   = udf_evt | (udf_q & ~clr_err_i);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign depth_o     = depth_q;
  assign empty_o     = (depth_q == '0);
  assign full_o      = (depth_q == DEPTH_X[CW-1:0]);
  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;

endmodule

// File: rtl/stack3.sv
// -----------------------------------------------------------------------------
// stack3 -- J1-style stack: cached top-of-stack register plus a shift-register
// tail of DEPTH-1 words, with pop-2, occupancy tracking and an indexed peek.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : stack3_if.slave
//     we/wd      write wd over the (new) top this cycle
//     delta      00 hold, 01 push, 11 pop, 10 pop-2
//     clr_err    clear sticky overflow/underflow
//     rd/nos     head and tail[0]
//     peek_idx   0 = head, k = tail[k-1], out of range = FILL
//     depth/empty/full/overflow/underflow  from stack_depth_ctr
// -----------------------------------------------------------------------------
module stack3
  import stack_pkg::*;
#(
  parameter  int          WIDTH = 16,
  parameter  int          DEPTH = 16,
  parameter  logic [15:0] FILL  = DEFAULT_FILL,
  localparam int          CW    = clog2(DEPTH + 1),
  localparam int          IW    = clog2(DEPTH)
) (
  input logic     clk,
  input logic     rst,
  stack3_if.slave bus
);

  // The 16-bit pattern is repeated to cover WIDTH, then cut to WIDTH from
  // the LSB end, which handles both narrower and wider words.
  localparam int               FILL_REP = (WIDTH + 15) / 16;
  localparam logic [WIDTH-1:0] FILL_W   = WIDTH'({FILL_REP{FILL}});
  localparam int               TAIL_N   = DEPTH - 1;
  localparam int               PEEK_N   = 1 << IW;

  delta_e           op;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q [TAIL_N];
  logic [WIDTH-1:0] tail_d [TAIL_N];
  // Tail followed by two FILL words: pops read past the bottom into FILL,
  // which also covers pop-2 when the tail holds a single word.
  logic [WIDTH-1:0] ext    [TAIL_N + 2];
  logic [WIDTH-1:0] ent    [PEEK_N];

  assign op = delta_e'(bus.delta);

  always_comb begin
    for (int i = 0; i < TAIL_N; i++) ext[i] = tail_q[i];
    ext[TAIL_N]     = FILL_W;
    ext[TAIL_N + 1] = FILL_W;
  end

  always_comb begin
    tail_d = tail_q;
    head_d = head_q;
    case (op)
      D_HOLD: ;
      D_PUSH: begin
        tail_d[0] = head_q;
        for (int i = 1; i < TAIL_N; i++) tail_d[i] = tail_q[i-1];
      end
      D_POP: begin
        for (int i = 0; i < TAIL_N; i++) tail_d[i] = ext[i+1];
        head_d = ext[0];
      end
      D_POP2: begin
        for (int i = 0; i < TAIL_N; i++) tail_d[i] = ext[i+2];
        head_d = ext[1];
      end
    endcase
    // A write always lands on the post-move top (ALU result over the pop).
    if (bus.we) head_d = bus.wd;
  end

  // NOTE: the tail is a shift register whose reset contents are observable
  // (nos, peek, values popped into the head), so every word is reset to
  // FILL rather than left as an unreset memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      for (int i = 0; i < TAIL_N; i++) tail_q[i] <= FILL_W;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Peek table padded to a power of two so any index reads a defined word.
  always_comb begin
    for (int i = 0; i < PEEK_N; i++) ent[i] = FILL_W;
    ent[0] = head_q;
    for (int i = 1; i < DEPTH; i++) ent[i] = tail_q[i-1];
  end

  assign bus.rd        = head_q;
  assign bus.nos       = tail_q[0];
  assign bus.peek_data = ent[bus.peek_idx];

  stack_depth_ctr #(
    .DEPTH (DEPTH)
  ) u_depth_ctr (
    .clk         (clk),
    .rst         (rst),
    .delta_i     (op),
    .clr_err_i   (bus.clr_err),
    .depth_o     (bus.depth),
    .empty_o     (bus.empty),
    .full_o      (bus.full),
    .overflow_o  (bus.overflow),
    .underflow_o (bus.underflow)
  );

endmodule

// File: tb/tb_stack3.sv
// -----------------------------------------------------------------------------
// tb_stack3 -- directed and random checks of stack3 (WIDTH 16, DEPTH 4)
// against a list-based reference model of the stack contents.
// -----------------------------------------------------------------------------
module tb_stack3;
  import stack_pkg::*;

  localparam int          WIDTH = 16;
  localparam int          DEPTH = 4;
  localparam logic [15:0] FILL  = 16'h55aa;

  logic clk = 1'b0;
  logic rst;

  stack3_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  stack3 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: m holds every storage word, m[0] being the top;
  // cnt is the number of valid entries; ovf/udf are the sticky flags.
  logic [15:0] m [$];
  int          cnt;
  bit          ovf, udf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m = {};
    m.push_back(16'h0000);
    repeat (DEPTH - 1) m.push_back(FILL);
    cnt = 0;
    ovf = 1'b0;
    udf = 1'b0;
  endtask

  task automatic model_apply(input bit we, input logic [1:0] d,
                             input logic [15:0] wd, input bit clr);
    bit eo = 1'b0;
    bit eu = 1'b0;
    case (d)
      2'b01: begin
        m.push_front(m[0]);
        void'(m.pop_back());
        if (cnt == DEPTH) eo = 1'b1; else cnt++;
      end
      2'b11: begin
        void'(m.pop_front());
        m.push_back(FILL);
        if (cnt == 0) eu = 1'b1; else cnt--;
      end
      2'b10: begin
        repeat (2) begin
          void'(m.pop_front());
          m.push_back(FILL);
        end
        if (cnt < 2) begin eu = 1'b1; cnt = 0; end
        else cnt -= 2;
      end
      default: ;
    endcase
    if (we) m[0] = wd;
    ovf = eo | (ovf & !clr);
    udf = eu | (udf & !clr);
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".rd"},    bus.rd,        m[0]);
    check({tag, ".nos"},   bus.nos,       m[1]);
    check({tag, ".peek"},  bus.peek_data, m[bus.peek_idx]);
    check({tag, ".depth"}, bus.depth,     cnt);
    check({tag, ".empty"}, bus.empty,     cnt == 0);
    check({tag, ".full"},  bus.full,      cnt == DEPTH);
    check({tag, ".ovf"},   bus.overflow,  ovf);
    check({tag, ".udf"},   bus.underflow, udf);
  endtask

  task automatic step(input string tag, input bit we, input logic [1:0] d,
                      input logic [15:0] wd, input bit clr, input logic [1:0] idx);
    @(negedge clk);
    bus.we       = we;
    bus.delta    = d;
    bus.wd       = wd;
    bus.clr_err  = clr;
    bus.peek_idx = idx;
    @(posedge clk);
    model_apply(we, d, wd, clr);
    #1;
    compare_all(tag);
  endtask

  // Pulses rst between clock edges and checks the reset values before any
  // further edge arrives.
  task automatic async_reset(input string tag);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all(tag);
    check({tag, ".rd0"},  bus.rd,  16'h0000);
    check({tag, ".nos0"}, bus.nos, FILL);
    bus.we      = 1'b0;
    bus.delta   = 2'b00;
    bus.clr_err = 1'b0;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.we       = 1'b0;
    bus.delta    = 2'b00;
    bus.wd       = '0;
    bus.clr_err  = 1'b0;
    bus.peek_idx = '0;
    model_reset();
    #12;
    compare_all("reset");
    check("reset.rd",  bus.rd,  16'h0000);
    check("reset.nos", bus.nos, 16'h55aa);
    check("reset.empty", bus.empty, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    step("idle", 1'b0, 2'b00, 16'h0000, 1'b0, 2'd0);

    // Three pushes.
    step("push1", 1'b1, 2'b01, 16'h1111, 1'b0, 2'd1);
    step("push2", 1'b1, 2'b01, 16'h2222, 1'b0, 2'd2);
    step("push3", 1'b1, 2'b01, 16'h3333, 1'b0, 2'd2);
    check("push3.rd",    bus.rd,        16'h3333);
    check("push3.nos",   bus.nos,       16'h2222);
    check("push3.peek2", bus.peek_data, 16'h1111);
    bus.peek_idx = 2'd3;
    #1;
    check("push3.peek3", bus.peek_data, 16'h0000);
    check("push3.depth", bus.depth,     3);

    // Fill up and overflow.
    step("push4", 1'b1, 2'b01, 16'h4444, 1'b0, 2'd3);
    check("push4.full", bus.full, 1'b1);
    check("push4.ovf",  bus.overflow, 1'b0);
    step("push5", 1'b1, 2'b01, 16'h5555, 1'b0, 2'd3);
    check("push5.ovf",   bus.overflow,  1'b1);
    check("push5.depth", bus.depth,     4);
    check("push5.peek3", bus.peek_data, 16'h2222);
    step("clr_ovf", 1'b0, 2'b00, 16'h0000, 1'b1, 2'd0);
    check("clr_ovf.ovf", bus.overflow, 1'b0);

    // Pop-2, then pop with write.
    step("pop2", 1'b0, 2'b10, 16'h0000, 1'b0, 2'd2);
    check("pop2.rd",    bus.rd,        16'h3333);
    check("pop2.nos",   bus.nos,       16'h2222);
    check("pop2.peek2", bus.peek_data, 16'h55aa);
    check("pop2.depth", bus.depth,     2);
    step("popw", 1'b1, 2'b11, 16'habcd, 1'b0, 2'd1);
    check("popw.rd",    bus.rd,    16'habcd);
    check("popw.depth", bus.depth, 1);

    // Underflow, and set beating clear.
    step("pop_to0", 1'b0, 2'b11, 16'h0000, 1'b0, 2'd0);
    step("pop_udf", 1'b0, 2'b11, 16'h0000, 1'b0, 2'd0);
    check("pop_udf.udf",   bus.underflow, 1'b1);
    check("pop_udf.depth", bus.depth,     0);
    step("pop_clr", 1'b0, 2'b11, 16'h0000, 1'b1, 2'd0);
    check("pop_clr.udf", bus.underflow, 1'b1);
    step("clr_udf", 1'b0, 2'b00, 16'h0000, 1'b1, 2'd0);
    check("clr_udf.udf", bus.underflow, 1'b0);

    // Async reset in the middle of a push burst.
    for (int i = 0; i < 3; i++)
      step("burst", 1'b1, 2'b01, 16'($urandom), 1'b0, 2'($urandom_range(0, 3)));
    async_reset("arst");
    step("post_rst", 1'b1, 2'b01, 16'h0042, 1'b0, 2'd0);
    check("post_rst.rd",    bus.rd,    16'h0042);
    check("post_rst.depth", bus.depth, 1);

    // Random traffic, with one more async reset partway through.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom), 2'($urandom_range(0, 3)), 16'($urandom),
           ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)));
      if (i == 200) async_reset("rand_arst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
